// File: rtl/core_booth_r4.sv
// Radix-4 Booth multiplier for the RV64M/RV32M multiply ops (MUL, MULH, MULHSU, MULHU).
// It retires two multiplier bits per cycle and uses valid/ready handshakes on both sides.
module core_booth_r4 #(
    parameter int XLEN = 64
) (
    input  logic            i_mul_clk,
    input  logic            i_mul_rstn,
    input  logic            i_mul_valid,
    output logic            o_mul_ready,
    input  logic [1:0]      i_mul_op,
    input  logic [XLEN-1:0] i_mul_rs1,
    input  logic [XLEN-1:0] i_mul_rs2,
    input  logic            i_mul_flush,
    output logic            o_mul_valid,
    input  logic            i_mul_result_ready,
    output logic [XLEN-1:0] o_mul_result,
    output logic            o_mul_busy
);

    localparam int W  = XLEN + 2;
    localparam int N  = W / 2;
    localparam int CW = $clog2(N + 1);
    localparam logic [W:0] ONE = (W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      op_q;
    logic [W:0]      mcand_q;
    logic [W:0]      acc_q;   // upper half of the product register, sign-extended
    logic [W:0]      mplr_q;  // lower half: {multiplier, q(-1)}; product bits shift in from the top
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] result_q;

    logic            accept;
    logic            rs1_sext, rs2_sext;
    logic [W:0]      m2, pp, sum;

    assign accept   = (state_q == IDLE) && i_mul_valid && !i_mul_flush;
    assign rs1_sext = (i_mul_op != 2'b11) & i_mul_rs1[XLEN-1];
    assign rs2_sext = ~i_mul_op[1] & i_mul_rs2[XLEN-1];

    always_ff @(posedge i_mul_clk) begin
        if (!i_mul_rstn) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? CALC : IDLE;
            CALC:    state_d = (cnt_q == '0) ? DONE : CALC;
            DONE:    state_d = i_mul_result_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (i_mul_flush) state_d = IDLE;
    end

    always_comb begin
        o_mul_ready = 1'b0;
        o_mul_valid = 1'b0;
        o_mul_busy  = 1'b0;
        case (state_q)
            IDLE:    o_mul_ready = 1'b1;
            CALC:    o_mul_busy  = 1'b1;
            DONE:    begin o_mul_valid = 1'b1; o_mul_busy = 1'b1; end
            default: o_mul_ready = 1'b0;
        endcase
    end

    // Booth recoding of {q1, q0, q(-1)}; negation is invert-plus-one.
    always_comb begin
        m2 = {mcand_q[W-1:0], 1'b0};
        case (mplr_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = m2;
            3'b100:         pp = ~m2 + ONE;
            3'b101, 3'b110: pp = ~mcand_q + ONE;
            default:        pp = '0;
        endcase
        sum = acc_q + pp;
    end

    always_ff @(posedge i_mul_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!i_mul_rstn) begin
            op_q     <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (!i_mul_flush) begin
            case (state_q)
                IDLE: if (i_mul_valid) begin
                    op_q    <= i_mul_op;
                    mcand_q <= {{3{rs1_sext}}, i_mul_rs1};
                    acc_q   <= '0;
                    mplr_q  <= {{2{rs2_sext}}, i_mul_rs2, 1'b0};
                    cnt_q   <= CW'(N);
                end
                CALC: if (cnt_q != '0) begin
                    acc_q  <= {{2{sum[W]}}, sum[W:2]};
                    mplr_q <= {sum[1:0], mplr_q[W:2]};
                    cnt_q  <= cnt_q - CW'(1);
                end else begin
                    // Product bit k sits in mplr_q[k+1] below W and in acc_q[k-W] from W upwards.
                    result_q <= (op_q == 2'b00) ? mplr_q[XLEN:1]
                                                : {acc_q[XLEN-3:0], mplr_q[W:W-1]};
                end
                default: ;
            endcase
        end
    end

    assign o_mul_result = result_q;

endmodule
